// File: rtl/axi_stream_processor.sv
// Purpose : inline AXI4-Stream word transform (pass / byte reverse / add constant) chosen by mode.
// Latency : 1 cycle from input accept to output valid, through a single output register stage.
// Backpressure: s_axis_tready = !m_axis_tvalid || m_axis_tready, so a stalled output holds the input off.
//
// Ports:
//   aclk, aresetn             clock; asynchronous reset, active-high (the name is historical)
//   s_axis_tdata/tkeep/tlast  input beat, qualified by s_axis_tvalid / s_axis_tready
//   m_axis_tdata/tkeep/tlast  output beat, qualified by m_axis_tvalid / m_axis_tready
//   mode                      0 pass, 1 byte reverse, 2 add constant_value, 3 pass
//   constant_value            addend for mode 2, sampled when the beat is accepted
module axi_stream_processor #(
  parameter int TDATA_WIDTH = 32
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [TDATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                     s_axis_tlast,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  output logic [TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [TDATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                     m_axis_tlast,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  input  logic [1:0]               mode,
  input  logic [TDATA_WIDTH-1:0]   constant_value
);

  localparam int KEEP_WIDTH = TDATA_WIDTH / 8;

  logic [TDATA_WIDTH-1:0] nxt_data;
  logic [KEEP_WIDTH-1:0]  nxt_keep;
  logic                   accept;

  // The output register can take a new beat when it is empty or being drained
  // on this same edge; held low for as long as reset is asserted.
  assign s_axis_tready = !aresetn && (!m_axis_tvalid || m_axis_tready);
  assign accept        = s_axis_tvalid && s_axis_tready;

  // tkeep never masks data: null bytes are transformed and carried like any other.
  always_comb begin
    nxt_data = s_axis_tdata;
    nxt_keep = s_axis_tkeep;
    case (mode)
      2'd1: begin
        // Each keep bit moves with its byte.
        for (int i = 0; i < KEEP_WIDTH; i++) begin
          nxt_data[8*i +: 8] = s_axis_tdata[8*(KEEP_WIDTH-1-i) +: 8];
          nxt_keep[i]        = s_axis_tkeep[KEEP_WIDTH-1-i];
        end
      end
      2'd2: nxt_data = s_axis_tdata + constant_value;  // carry-out dropped (wraps)
      default: ;
    endcase
  end

  always_ff @(posedge aclk or posedge aresetn) begin
    if (aresetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
    end else if (accept) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= nxt_data;
      m_axis_tkeep  <= nxt_keep;
      m_axis_tlast  <= s_axis_tlast;
    end else if (m_axis_tready) begin
      // Beat consumed with nothing behind it; the payload is left as-is.
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_stream_processor.sv
// Purpose : self-checking bench for axi_stream_processor with a scoreboard and a reference model.
// Latency : expects each accepted beat to appear on the output in order, one cycle after acceptance at the earliest.
// Backpressure: randomly and directedly stalls m_axis_tready; checks hold-stability and s_axis_tready.
module tb_axi_stream_processor;

  localparam int TW = 32;
  localparam int KW = TW / 8;

  typedef struct packed {
    logic [TW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
  } beat_t;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b1;
  logic [TW-1:0] s_axis_tdata = '0;
  logic [KW-1:0] s_axis_tkeep = '0;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic [TW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tlast;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic [1:0]    mode = 2'd0;
  logic [TW-1:0] constant_value = '0;

  int    tests = 0;
  int    fails = 0;
  beat_t exp_q[$];
  bit    rand_rdy = 1'b0;
  bit    stalled = 1'b0;
  beat_t held;

  axi_stream_processor #(.TDATA_WIDTH(TW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .mode(mode), .constant_value(constant_value)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: byte reversal via the streaming operator, addition as plain modular arithmetic.
  function automatic beat_t model(input logic [TW-1:0] din, input logic [KW-1:0] kin,
                                  input logic lin, input logic [1:0] m, input logic [TW-1:0] c);
    beat_t r;
    r.d = din;
    r.k = kin;
    r.l = lin;
    if (m == 2'd1) begin
      r.d = {<<8{din}};
      r.k = {<<{kin}};
    end else if (m == 2'd2) begin
      r.d = TW'((din + c) % (64'd1 << TW));
    end
    return r;
  endfunction

  // Present a beat (called at posedge+1), push its expected result when the accept edge is next.
  task automatic send(input logic [TW-1:0] d, input logic [KW-1:0] k, input logic l,
                      input logic [1:0] m, input logic [TW-1:0] c, input int idle);
    int  waited = 0;
    bit  ok = 1'b0;
    s_axis_tdata   = d;
    s_axis_tkeep   = k;
    s_axis_tlast   = l;
    mode           = m;
    constant_value = c;
    s_axis_tvalid  = 1'b1;
    while (!ok && waited < 200) begin
      @(negedge aclk);
      ok = s_axis_tready;
      waited++;
    end
    if (!ok) chk("accept_timeout", 64'(waited), 64'd0);
    else exp_q.push_back(model(d, k, l, m, c));
    @(posedge aclk); #1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = $urandom;  // garbage while idle must never reach the output
    mode          = 2'($urandom);
    repeat (idle) begin @(posedge aclk); #1; end
  endtask

  // Random downstream ready during the randomized phase.
  always @(posedge aclk) if (rand_rdy) begin
    #1 m_axis_tready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: pop and compare on every output handshake; check hold-stability under stall.
  always @(negedge aclk) begin
    if (aresetn) begin
      stalled = 1'b0;
    end else begin
      chk("s_tready_rule", 64'(s_axis_tready), 64'(!m_axis_tvalid || m_axis_tready));
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 64'(m_axis_tdata), 64'd0);
          tests++; fails++;
          $display("FAIL unexpected_output: got %h with empty scoreboard", m_axis_tdata);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("out_data", 64'(m_axis_tdata), 64'(e.d));
          chk("out_keep", 64'(m_axis_tkeep), 64'(e.k));
          chk("out_last", 64'(m_axis_tlast), 64'(e.l));
        end
        stalled = 1'b0;
      end else if (m_axis_tvalid) begin
        if (stalled) begin
          chk("stall_data", 64'(m_axis_tdata), 64'(held.d));
          chk("stall_keep", 64'(m_axis_tkeep), 64'(held.k));
          chk("stall_last", 64'(m_axis_tlast), 64'(held.l));
        end
        stalled = 1'b1;
        held.d  = m_axis_tdata;
        held.k  = m_axis_tkeep;
        held.l  = m_axis_tlast;
      end else begin
        stalled = 1'b0;
      end
    end
  end

  initial begin
    int waited;

    // Reset state while reset is held.
    repeat (2) @(posedge aclk);
    #2;
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_tdata",  64'(m_axis_tdata),  64'd0);
    chk("rst_tkeep",  64'(m_axis_tkeep),  64'd0);
    chk("rst_tlast",  64'(m_axis_tlast),  64'd0);
    chk("rst_tready", 64'(s_axis_tready), 64'd0);
    aresetn = 1'b0;
    @(negedge aclk);
    chk("post_rst_tready", 64'(s_axis_tready), 64'd1);
    @(posedge aclk); #1;

    // Directed vectors.
    send(32'h12345678, 4'hF, 1'b1, 2'd0, 32'h0, 2);
    send(32'h12345678, 4'b0011, 1'b0, 2'd1, 32'h0, 0);
    send(32'h12345678, 4'hF, 1'b1, 2'd3, 32'h0, 1);
    send(32'h12345678, 4'hF, 1'b0, 2'd2, 32'h5, 0);
    send(32'hFFFFFFFF, 4'hF, 1'b1, 2'd2, 32'hFFFFFFFF, 0);
    send(32'hAABBCCDD, 4'b1100, 1'b1, 2'd0, 32'h0, 2);

    // Backpressure: beat A parked at the output, beat B waiting at the input.
    m_axis_tready = 1'b0;
    send(32'hCAFEF00D, 4'b0111, 1'b1, 2'd1, 32'h0, 0);
    fork
      send(32'h01020304, 4'hF, 1'b0, 2'd2, 32'h10, 0);
      begin
        repeat (3) begin
          @(negedge aclk);
          chk("bp_s_tready", 64'(s_axis_tready), 64'd0);
          chk("bp_m_tvalid", 64'(m_axis_tvalid), 64'd1);
        end
        @(posedge aclk); #1;
        m_axis_tready = 1'b1;
      end
    join
    repeat (3) begin @(posedge aclk); #1; end
    chk("bp_drained", 64'(exp_q.size()), 64'd0);

    // Reset while a beat is pending at the output.
    m_axis_tready = 1'b0;
    send(32'hDEADBEEF, 4'hF, 1'b1, 2'd0, 32'h0, 0);
    @(negedge aclk);
    chk("pre_rst_tvalid", 64'(m_axis_tvalid), 64'd1);
    #2 aresetn = 1'b1;
    #1;
    chk("async_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    exp_q.delete();
    m_axis_tready = 1'b1;
    @(negedge aclk);
    chk("rst_hold_tready", 64'(s_axis_tready), 64'd0);
    @(posedge aclk); #3;
    aresetn = 1'b0;
    repeat (4) begin
      @(negedge aclk);
      chk("no_stale_beat", 64'(m_axis_tvalid), 64'd0);
    end
    @(posedge aclk); #1;

    // Randomized traffic with random downstream stalls.
    rand_rdy = 1'b1;
    for (int n = 0; n < 300; n++) begin
      send($urandom, KW'($urandom), 1'($urandom), 2'($urandom),
           ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom,
           $urandom_range(0, 2));
    end
    rand_rdy = 1'b0;
    @(posedge aclk); #1;
    m_axis_tready = 1'b1;
    waited = 0;
    while (exp_q.size() != 0 && waited < 50) begin
      @(posedge aclk); #1;
      waited++;
    end
    chk("final_drain", 64'(exp_q.size()), 64'd0);
    repeat (2) @(posedge aclk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
